// File: rtl/cen_pkg.sv
// cen_pkg: shared types and constants for the clock-enable generator.
//   state_t  - lock-tracking FSM state encoding
//   DEF_NUM  - numerator every channel holds after reset
//   DEF_DEN  - denominator every channel holds after reset
//   MAX_CH   - largest supported channel count
package cen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_NUM = 1;
  localparam int DEF_DEN = 8;
  localparam int MAX_CH  = 8;

endpackage

// File: rtl/cen_acc.sv
// cen_acc: single-channel fractional clock-enable accumulator.
// Emits cen at an average rate of num_r/den_r of clk using a phase
// accumulator that keeps the remainder, so the rate never drifts.
// Ports:
//   clk, rst_n  - clock / async active-low reset (already synchronised)
//   run         - channel may advance this cycle; low clears acc and cen
//   cfg_load    - latch num/den, clear acc and cen (beats run)
//   num, den    - ratio inputs, sampled only on cfg_load
//   cen         - registered one-cycle enable pulse
module cen_acc
  import cen_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             cen
);

  logic [WIDTH-1:0] num_r;
  logic [WIDTH-1:0] den_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic             disabled;
  logic             saturated;

  // One extra bit so acc + num_r can never wrap.
  assign sum       = {1'b0, acc} + {1'b0, num_r};
  assign disabled  = (num_r == '0) || (den_r == '0);
  // Ratio >= 1: fire every cycle and keep acc at 0 instead of letting the
  // remainder grow.
  assign saturated = (num_r >= den_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r <= WIDTH'(DEF_NUM);
      den_r <= WIDTH'(DEF_DEN);
      acc   <= '0;
      cen   <= 1'b0;
    end else if (cfg_load) begin
      num_r <= num;
      den_r <= den;
      acc   <= '0;
      cen   <= 1'b0;
    end else if (!run || disabled) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (saturated) begin
      acc <= '0;
      cen <= 1'b1;
    end else if (sum >= {1'b0, den_r}) begin
      acc <= WIDTH'(sum - {1'b0, den_r});
      cen <= 1'b1;
    end else begin
      acc <= WIDTH'(sum);
      cen <= 1'b0;
    end
  end

endmodule

// File: rtl/cen_gen.sv
// cen_gen: multi-channel fractional clock-enable generator gated by PLL lock.
// Enables only run once the PLL lock has been stable for HOLD_CYCLES.
// Ports:
//   clk       - system clock (PLL output)
//   rst_n     - async-assert active-low reset; release synchronised inside
//   locked    - PLL lock, asynchronous to clk
//   cfg_load  - one-cycle strobe latching num/den for all channels
//   num, den  - per-channel ratio, channel i at [i*WIDTH +: WIDTH]
//   cen       - per-channel one-cycle enable pulses
//   ready     - lock stable and enables running
module cen_gen
  import cen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    locked,
  input  logic                    cfg_load,
  input  logic [NUM_CH*WIDTH-1:0] num,
  input  logic [NUM_CH*WIDTH-1:0] den,
  output logic [NUM_CH-1:0]       cen,
  output logic                    ready
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("cen_gen: NUM_CH out of range");
  end

  // Reset: asserts asynchronously, releases after two clk edges.
  logic [1:0] rst_sync;
  logic       rst_i_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i_n = rst_sync[1];

  // Lock synchroniser; nothing downstream looks at raw locked.
  logic [1:0] lock_sync;
  logic       locked_s;

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) lock_sync <= '0;
    else          lock_sync <= {lock_sync[0], locked};
  end

  assign locked_s = lock_sync[1];

  // Lock FSM
  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt;
  logic          run;

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) state <= WAIT_LOCK;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (locked_s) state_nxt = HOLD;
      HOLD: begin
        if (!locked_s)                          state_nxt = WAIT_LOCK;
        else if (hold_cnt == CW'(HOLD_CYCLES-1)) state_nxt = RUN;
      end
      RUN:       if (!locked_s) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n)           hold_cnt <= '0;
    else if (state == HOLD) hold_cnt <= hold_cnt + CW'(1);
    else                    hold_cnt <= '0;
  end

  // ready tracks the state register; it falls on the same edge that leaves RUN.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) ready <= 1'b0;
    else          ready <= (state_nxt == RUN);
  end

  // Accumulators advance only while staying in RUN, so the edge that leaves
  // RUN on lock loss already clears cen instead of emitting a last pulse.
  assign run = (state == RUN) && (state_nxt == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cen_acc #(
      .WIDTH (WIDTH)
    ) u_acc (
      .clk      (clk),
      .rst_n    (rst_i_n),
      .run      (run),
      .cfg_load (cfg_load),
      .num      (num[i*WIDTH +: WIDTH]),
      .den      (den[i*WIDTH +: WIDTH]),
      .cen      (cen[i])
    );
  end

endmodule
